// File: rtl/store_merge_rmw_if.sv
// Store request and word-bus bundle for store_merge_rmw.
// master: MEM-stage request + bus responder; slave: the merge unit.
interface store_merge_rmw_if;
  logic        req_valid;
  logic        req_ready;
  logic        byte_op;
  logic        half_op;
  logic        swr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [3:0]  be;
  logic        done;
  logic        err;

  modport master (
    output req_valid, byte_op, half_op, swr,
    output addr, wdata, mem_rdata, mem_ack,
    input  req_ready, mem_addr, mem_rd, mem_wr,
    input  mem_wdata, be, done, err
  );

  modport slave (
    input  req_valid, byte_op, half_op, swr,
    input  addr, wdata, mem_rdata, mem_ack,
    output req_ready, mem_addr, mem_rd, mem_wr,
    output mem_wdata, be, done, err
  );
endinterface

// File: rtl/store_merge_rmw.sv
// Store byte-lane processor and read-modify-write sequencer.
// Ports: clk, reset (sync, active-high), bus (store_merge_rmw_if.slave).
module store_merge_rmw (
  input  logic clk,
  input  logic reset,
  store_merge_rmw_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, READ, WRITE, FIN
  } state_t;

  state_t      state, state_nx;
  logic [31:0] lane, lane_nx;
  logic [31:0] addr_nx, wdata_nx;
  logic [3:0]  be_nx;
  logic        mis, mis_nx;

  logic [1:0]  k;
  logic        is_swr, is_b, is_h, is_w;
  logic [3:0]  dec_be;
  logic [31:0] dec_lane;
  logic        dec_mis;
  logic [31:0] merged;

  // One-hot select encodes the swr > byte > half > word priority.
  assign k      = bus.addr[1:0];
  assign is_swr = bus.swr;
  assign is_b   = bus.byte_op & ~bus.swr;
  assign is_h   = bus.half_op & ~bus.swr & ~bus.byte_op;
  assign is_w   = ~(bus.swr | bus.byte_op | bus.half_op);

  always_comb begin
    dec_be   = 4'b1111;
    dec_lane = bus.wdata;
    dec_mis  = 1'b0;
    unique case (1'b1)
      is_swr: begin
        dec_be   = 4'b1111 << k;
        dec_lane = bus.wdata << {k, 3'b000};
      end
      is_b: begin
        dec_be   = 4'b0001 << k;
        dec_lane = {4{bus.wdata[7:0]}};
      end
      is_h: begin
        dec_be   = k[1] ? 4'b1100 : 4'b0011;
        dec_lane = {2{bus.wdata[15:0]}};
        dec_mis  = k[0];
      end
      is_w: begin
        dec_be   = 4'b1111;
        dec_lane = bus.wdata;
        dec_mis  = (k != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = bus.be[i] ? lane[8*i +: 8]
                                   : bus.mem_rdata[8*i +: 8];
    end
  end

  always_comb begin
    state_nx = state;
    lane_nx  = lane;
    be_nx    = bus.be;
    addr_nx  = bus.mem_addr;
    wdata_nx = bus.mem_wdata;
    mis_nx   = mis;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          be_nx   = dec_be;
          lane_nx = dec_lane;
          addr_nx = {bus.addr[31:2], 2'b00};
          mis_nx  = dec_mis;
          if (dec_mis) begin
            state_nx = FIN;
          end else if (dec_be == 4'b1111) begin
            wdata_nx = dec_lane;
            state_nx = WRITE;
          end else begin
            state_nx = READ;
          end
        end
      end
      READ: begin
        if (bus.mem_ack) begin
          wdata_nx = merged;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_ack) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lane          <= '0;
      mis           <= 1'b0;
      bus.be        <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_nx;
      lane          <= lane_nx;
      mis           <= mis_nx;
      bus.be        <= be_nx;
      bus.mem_addr  <= addr_nx;
      bus.mem_wdata <= wdata_nx;
      bus.req_ready <= (state_nx == IDLE);
      bus.mem_rd    <= (state_nx == READ);
      bus.mem_wr    <= (state_nx == WRITE);
      bus.done      <= (state_nx == FIN);
      bus.err       <= (state_nx == FIN) & mis_nx;
    end
  end
endmodule
